pc_fetch_sequencer: RTL and testbench

- Program-counter stage feeding the 30-bit word-address adder path (PC<31:2>).
- Holds the PC, runs the instruction-fetch handshake with instruction memory, and selects the next PC each instruction: sequential, branch, jump or halt.
- Computes PC+1 and PC+1+sext(imm) on 30-bit word addresses using the team's ripple adder.
- Adds a fetch-timeout watchdog that latches a fault.

---
 rtl/pc_fetch_sequencer_if.sv | 10 +
 rtl/pc_fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the PC stage and instruction memory.
// The master side issues word-address fetch requests; the slave side acknowledges them.
interface pc_fetch_sequencer_if;
  logic        req;
  logic [29:0] addr;
  logic        ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter stage. Holds the word-address PC and runs the fetch handshake.
// Chooses the next PC once per instruction: sequential, branch, jump or halt.
// A watchdog moves the block to a sticky FAULT state if memory never acknowledges.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  pc_fetch_sequencer_if.master        imem,
  input  logic                        branch_taken_i,
  input  logic [15:0]                 branch_imm_i,
  input  logic                        jump_en_i,
  input  logic [25:0]                 jump_target_i,
  input  logic                        halt_i,
  output logic                        instr_valid_o,
  output logic [29:0]                 pc_out_o,
  output logic [29:0]                 pc_plus1_o,
  output logic                        fault_o,
  output logic [2:0]                  state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [7:0]  TIMEOUT_C = ACK_TIMEOUT[7:0];
  localparam logic [29:0] RESET_PC  = RESET_VECTOR[31:2];

  // Ripple-carry adder for 30-bit word addresses; the carry-out is dropped so sums wrap.
  function automatic logic [29:0] ripple_add30(input logic [29:0] a, input logic [29:0] b);
    logic [29:0] sum;
    logic        carry;
    carry = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    return sum;
  endfunction

  state_t      state_q;
  logic [29:0] pc_q;
  logic [29:0] pc_d;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        valid_q;
  logic        fault_q;

  logic [29:0] pc_plus1_s;
  logic [29:0] branch_tgt_s;
  logic [29:0] jump_tgt_s;

  assign pc_plus1_s   = ripple_add30(pc_q, 30'd1);
  assign branch_tgt_s = ripple_add30(pc_plus1_s, {{14{branch_imm_i[15]}}, branch_imm_i});
  assign jump_tgt_s   = {pc_plus1_s[29:26], jump_target_i};

  // Next-PC selection with priority halt > jump > branch > sequential; only consumed in EXEC.
  always_comb begin
    pc_d = pc_q;
    if (halt_i) begin
      pc_d = pc_q;
    end else if (jump_en_i) begin
      pc_d = jump_tgt_s;
    end else if (branch_taken_i) begin
      pc_d = branch_tgt_s;
    end else begin
      pc_d = pc_plus1_s;
    end
  end

  // Fetch FSM with registered handshake, strobe and fault outputs; PC written only on EXEC->WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_WAIT;
          cnt_q   <= 8'd0;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        ST_WAIT: begin
          if (imem.ack) begin
            // Ack wins even on the cycle the watchdog would expire.
            state_q <= ST_EXEC;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (cnt_q == TIMEOUT_C) begin
            state_q <= ST_FAULT;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        ST_EXEC: begin
          valid_q <= 1'b0;
          if (halt_i) begin
            state_q <= ST_HALT;
            req_q   <= 1'b0;
          end else begin
            pc_q    <= pc_d;
            state_q <= ST_WAIT;
            req_q   <= 1'b1;
          end
        end
        ST_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        ST_FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          // Corrupted state encoding: park safely in FAULT.
          state_q <= ST_FAULT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem.req      = req_q;
  assign imem.addr     = pc_q;
  assign instr_valid_o = valid_q;
  assign pc_out_o      = pc_q;
  assign pc_plus1_o    = pc_plus1_s;
  assign fault_o       = fault_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized
// instruction streams compared against an arithmetic reference model.
module tb_pc_fetch_sequencer;

  localparam longint unsigned M30 = 64'd1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if mem_if ();
  pc_fetch_sequencer_if mem_j ();

  logic        branch_taken, jump_en, halt;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;

  logic        instr_valid, fault;
  logic [29:0] pc_out, pc_plus1;
  logic [2:0]  state;

  logic        j_instr_valid, j_fault;
  logic [29:0] j_pc_out, j_pc_plus1;
  logic [2:0]  j_state;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem(mem_if.master),
    .branch_taken_i(branch_taken), .branch_imm_i(branch_imm),
    .jump_en_i(jump_en), .jump_target_i(jump_target), .halt_i(halt),
    .instr_valid_o(instr_valid), .pc_out_o(pc_out), .pc_plus1_o(pc_plus1),
    .fault_o(fault), .state_o(state)
  );

  // Second instance reset near the top of the address space to exercise jump high bits.
  pc_fetch_sequencer #(.RESET_VECTOR(32'hBFFF_FFFC)) dut_j (
    .clk(clk), .rst(rst), .imem(mem_j.master),
    .branch_taken_i(branch_taken), .branch_imm_i(branch_imm),
    .jump_en_i(jump_en), .jump_target_i(jump_target), .halt_i(halt),
    .instr_valid_o(j_instr_valid), .pc_out_o(j_pc_out), .pc_plus1_o(j_pc_plus1),
    .fault_o(j_fault), .state_o(j_state)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [29:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC from the architectural rules, using plain integer arithmetic.
  function automatic logic [29:0] ref_next(input logic [29:0] pc, input bit j, input logic [25:0] jt,
                                           input bit b, input logic [15:0] imm);
    longint unsigned p1;
    longint          t;
    p1 = (longint'(pc) + 1) % M30;
    if (j) begin
      return 30'((p1 / (64'd1 << 26)) * (64'd1 << 26) + longint'(jt));
    end else if (b) begin
      t = longint'(p1) + longint'($signed(imm));
      return 30'(((t % longint'(M30)) + longint'(M30)) % longint'(M30));
    end else begin
      return 30'(p1);
    end
  endfunction

  task automatic junk_controls();
    halt         = 1'($urandom);
    jump_en      = 1'($urandom);
    branch_taken = 1'($urandom);
    branch_imm   = 16'($urandom);
    jump_target  = 26'($urandom);
  endtask

  task automatic clear_controls();
    halt = 1'b0; jump_en = 1'b0; branch_taken = 1'b0;
    branch_imm = 16'd0; jump_target = 26'd0;
  endtask

  // One instruction: 'delay' ack-less WAIT cycles, an acked WAIT cycle, then EXEC with the given controls.
  task automatic fetch(input int delay, input bit h, input bit j, input logic [25:0] jt,
                       input bit b, input logic [15:0] imm);
    for (int i = 0; i <= delay; i++) begin
      chk("wait_state", 32'(state), 32'd1);
      chk("wait_req", 32'(mem_if.req), 32'd1);
      chk("wait_addr", 32'(mem_if.addr), 32'(exp_pc));
      chk("wait_valid", 32'(instr_valid), 32'd0);
      mem_if.ack = (i == delay) ? 1'b1 : 1'b0;
      junk_controls();
      tick();
    end
    chk("exec_state", 32'(state), 32'd2);
    chk("exec_valid", 32'(instr_valid), 32'd1);
    chk("exec_req", 32'(mem_if.req), 32'd0);
    chk("exec_plus1", 32'(pc_plus1), 32'((longint'(exp_pc) + 1) % M30));
    mem_if.ack   = 1'($urandom);
    halt         = h;
    jump_en      = j;
    jump_target  = jt;
    branch_taken = b;
    branch_imm   = imm;
    tick();
    if (!h) exp_pc = ref_next(exp_pc, j, jt, b, imm);
    chk("post_state", 32'(state), h ? 32'd3 : 32'd1);
    chk("post_pc", 32'(pc_out), 32'(exp_pc));
    chk("post_valid", 32'(instr_valid), 32'd0);
    chk("post_fault", 32'(fault), 32'd0);
    mem_if.ack = 1'b0;
    clear_controls();
  endtask

  // Hold reset for two edges, check reset state, release and step through IDLE into WAIT.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", 32'(mem_if.req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'h0010_0000);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_req", 32'(mem_if.req), 32'd0);
    tick();
    exp_pc = 30'h0010_0000;
  endtask

  initial begin
    rst = 1'b1;
    mem_if.ack = 1'b0;
    mem_j.ack  = 1'b0;
    clear_controls();
    do_reset();

    // Zero-wait sequential fetches.
    fetch(0, 0, 0, 26'd0, 0, 16'd0); chk("seq1", 32'(pc_out), 32'h0010_0001);
    fetch(0, 0, 0, 26'd0, 0, 16'd0); chk("seq2", 32'(pc_out), 32'h0010_0002);
    fetch(0, 0, 0, 26'd0, 0, 16'd0);
    fetch(0, 0, 0, 26'd0, 0, 16'd0); chk("seq4", 32'(pc_out), 32'h0010_0004);

    // Backward and forward branches from 0x00100004.
    fetch(0, 0, 0, 26'd0, 1, 16'hFFFE); chk("br_back", 32'(pc_out), 32'h0010_0003);
    fetch(0, 0, 0, 26'd0, 0, 16'd0);    chk("seq5", 32'(pc_out), 32'h0010_0004);
    fetch(0, 0, 0, 26'd0, 1, 16'h0010); chk("br_fwd", 32'(pc_out), 32'h0010_0015);

    // Wrap-around: jump to 0, branch back to 0x3FFFFFFF, then sequential wraps to 0.
    fetch(1, 0, 1, 26'd0, 0, 16'd0);    chk("jmp_zero", 32'(pc_out), 32'h0000_0000);
    fetch(2, 0, 0, 26'd0, 1, 16'hFFFE); chk("br_wrap", 32'(pc_out), 32'h3FFF_FFFF);
    fetch(0, 0, 0, 26'd0, 0, 16'd0);    chk("seq_wrap", 32'(pc_out), 32'h0000_0000);

    // Late acks at the watchdog boundary still succeed.
    fetch(14, 0, 0, 26'd0, 0, 16'd0);
    fetch(15, 0, 0, 26'd0, 0, 16'd0);
    chk("late_ack_fault", 32'(fault), 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      fetch(int'($urandom_range(0, 15)), 0, ($urandom_range(0, 7) == 0), 26'($urandom),
            1'($urandom), 16'($urandom));
    end

    // Asynchronous reset in the middle of a WAIT.
    mem_if.ack = 1'b0;
    tick();
    tick();
    chk("mid_wait_req", 32'(mem_if.req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_req", 32'(mem_if.req), 32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_fault", 32'(fault), 32'd0);
    chk("async_pc", 32'(pc_out), 32'h0010_0000);
    chk("async_state", 32'(state), 32'd0);
    do_reset();
    fetch(0, 0, 0, 26'd0, 0, 16'd0); chk("resume", 32'(pc_out), 32'h0010_0001);

    // Watchdog: withhold ack; FAULT on the 16th WAIT edge.
    mem_if.ack = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_waiting", 32'(state), 32'd1);
    end
    tick();
    chk("to_state", 32'(state), 32'd4);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req", 32'(mem_if.req), 32'd0);
    chk("to_pc", 32'(pc_out), 32'(exp_pc));
    for (int i = 0; i < 5; i++) begin
      mem_if.ack = 1'($urandom);
      junk_controls();
      tick();
      chk("fault_sticky", 32'(fault), 32'd1);
      chk("fault_state", 32'(state), 32'd4);
      chk("fault_valid", 32'(instr_valid), 32'd0);
      chk("fault_pc", 32'(pc_out), 32'(exp_pc));
    end
    mem_if.ack = 1'b0;
    clear_controls();
    do_reset();

    // Halt has priority over jump and branch; HALT ignores ack pulses.
    fetch(0, 0, 0, 26'd0, 0, 16'd0);
    fetch(0, 1, 1, 26'h155_5555, 1, 16'h0040);
    for (int i = 0; i < 20; i++) begin
      mem_if.ack = 1'($urandom);
      junk_controls();
      tick();
      chk("halt_req", 32'(mem_if.req), 32'd0);
      chk("halt_state", 32'(state), 32'd3);
      chk("halt_pc", 32'(pc_out), 32'h0010_0001);
      chk("halt_valid", 32'(instr_valid), 32'd0);
    end
    mem_if.ack = 1'b0;
    clear_controls();

    // Jump keeps pc_plus1[29:26]: from 0x2FFFFFFF to 0x30ABCDEF.
    do_reset();
    chk("j_first_addr", 32'(mem_j.addr), 32'h2FFF_FFFF);
    mem_j.ack = 1'b1;
    tick();
    chk("j_exec", 32'(j_state), 32'd2);
    mem_j.ack   = 1'b0;
    jump_en     = 1'b1;
    jump_target = 26'h0AB_CDEF;
    tick();
    chk("j_state", 32'(j_state), 32'd1);
    chk("j_addr", 32'(mem_j.addr), 32'h30AB_CDEF);
    clear_controls();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
